// File: rtl/serial_parity_checker_if.sv
// Serial parity checker bus: frame input controls and status outputs.
//   master: drives clear, odd_mode, bit_valid, bit_in; observes status.
//   slave : the checker; drives busy, frame_done, pec, err_cnt.
interface serial_parity_checker_if #(
   parameter int unsigned CNT_W = 8
);
   logic             clear;
   logic             odd_mode;
   logic             bit_valid;
   logic             bit_in;
   logic             busy;
   logic             frame_done;
   logic             pec;
   logic [CNT_W-1:0] err_cnt;

   modport master (
      output clear, odd_mode, bit_valid, bit_in,
      input  busy, frame_done, pec, err_cnt
   );

   modport slave (
      input  clear, odd_mode, bit_valid, bit_in,
      output busy, frame_done, pec, err_cnt
   );
endinterface

// File: rtl/serial_parity_checker.sv
// Serial parity checker: accepts DATA_W data bits followed by one parity bit,
// flags a parity error per frame and keeps a saturating error count.
//   clk, rst_n : clock, asynchronous active-low reset
//   sp.clear   : synchronous clear, aborts the frame and zeroes the count
//   sp.odd_mode: parity sense, sampled on the parity-bit cycle only
//   sp.bit_valid / sp.bit_in : serial bit stream
//   sp.busy, sp.frame_done, sp.pec, sp.err_cnt : registered status
module serial_parity_checker #(
   parameter int unsigned DATA_W = 4,
   parameter int unsigned CNT_W  = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   serial_parity_checker_if.slave sp
);
   localparam int unsigned IDX_W = $clog2(DATA_W + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W);

   logic [IDX_W-1:0] idx_q, idx_d;
   logic             acc_q, acc_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pec_q, pec_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             result_c;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q  <= '0;
         acc_q  <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         pec_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         idx_q  <= idx_d;
         acc_q  <= acc_d;
         busy_q <= busy_d;
         done_q <= done_d;
         pec_q  <= pec_d;
         cnt_q  <= cnt_d;
      end
   end

   // Error result if the current bit is the parity bit.
   assign result_c = acc_q ^ sp.bit_in ^ sp.odd_mode;

   // Next-state: clear beats bit_valid beats hold.
   always_comb begin
      idx_d  = idx_q;
      acc_d  = acc_q;
      done_d = 1'b0;
      pec_d  = pec_q;
      cnt_d  = cnt_q;
      if (sp.clear) begin
         idx_d = '0;
         acc_d = 1'b0;
         pec_d = 1'b0;
         cnt_d = '0;
      end else if (sp.bit_valid) begin
         if (idx_q == LAST_IDX) begin
            idx_d  = '0;
            acc_d  = 1'b0;
            pec_d  = result_c;
            done_d = 1'b1;
            if (result_c && (cnt_q != '1)) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end else begin
            idx_d = idx_q + IDX_W'(1);
            acc_d = acc_q ^ sp.bit_in;
         end
      end
      // busy tracks the index it will hold, so it is a plain register output.
      busy_d = (idx_d != '0);
   end

   assign sp.busy       = busy_q;
   assign sp.frame_done = done_q;
   assign sp.pec        = pec_q;
   assign sp.err_cnt    = cnt_q;
endmodule

// File: tb/tb_serial_parity_checker.sv
// Bench for serial_parity_checker: two instances (CNT_W=8 and CNT_W=2) share
// one stimulus stream; a queue-based frame model is compared every cycle.
module tb_serial_parity_checker;
   localparam int unsigned DATA_W = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_assert = 0;
   int   n_fail = 0;
   bit   run = 1'b0;

   serial_parity_checker_if #(.CNT_W(8)) ifm ();
   serial_parity_checker_if #(.CNT_W(2)) ifs ();

   assign ifs.clear     = ifm.clear;
   assign ifs.odd_mode  = ifm.odd_mode;
   assign ifs.bit_valid = ifm.bit_valid;
   assign ifs.bit_in    = ifm.bit_in;

   serial_parity_checker #(.DATA_W(DATA_W), .CNT_W(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .sp(ifm));
   serial_parity_checker #(.DATA_W(DATA_W), .CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .sp(ifs));

   always #5 clk = ~clk;

   // Reference model: collect the frame's bits, judge parity by counting ones.
   bit q[$];
   bit m_pec = 1'b0;
   bit m_done = 1'b0;
   int m_cnt8 = 0;
   int m_cnt2 = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         m_pec = 1'b0; m_done = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
      end else if (ifm.clear) begin
         q.delete();
         m_pec = 1'b0; m_done = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
      end else if (ifm.bit_valid) begin
         if (q.size() < DATA_W) begin
            q.push_back(ifm.bit_in);
            m_done = 1'b0;
         end else begin
            int ones;
            bit err;
            ones = int'(ifm.bit_in);
            foreach (q[i]) ones += int'(q[i]);
            err = ifm.odd_mode ? (ones % 2 == 0) : (ones % 2 == 1);
            m_pec = err;
            m_done = 1'b1;
            if (err && m_cnt8 < 255) m_cnt8++;
            if (err && m_cnt2 < 3) m_cnt2++;
            q.delete();
         end
      end else begin
         m_done = 1'b0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      if (run) begin
         check("busy8", 32'(ifm.busy), 32'(q.size() != 0));
         check("done8", 32'(ifm.frame_done), 32'(m_done));
         check("pec8", 32'(ifm.pec), 32'(m_pec));
         check("cnt8", 32'(ifm.err_cnt), 32'(m_cnt8));
         check("busy2", 32'(ifs.busy), 32'(q.size() != 0));
         check("done2", 32'(ifs.frame_done), 32'(m_done));
         check("pec2", 32'(ifs.pec), 32'(m_pec));
         check("cnt2", 32'(ifs.err_cnt), 32'(m_cnt2));
      end
   end

   // All stimulus tasks start and end at posedge+2.
   task automatic send(input logic b, input logic om);
      ifm.bit_valid = 1'b1;
      ifm.bit_in    = b;
      ifm.odd_mode  = om;
      @(posedge clk); #2;
      ifm.bit_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #2; end
   endtask

   task automatic do_clear(input logic bv);
      ifm.clear     = 1'b1;
      ifm.bit_valid = bv;
      ifm.bit_in    = 1'b1;
      @(posedge clk); #2;
      ifm.clear     = 1'b0;
      ifm.bit_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [3:0] d, input logic p, input logic om);
      for (int i = 3; i >= 0; i--) send(d[i], om);
      send(p, om);
   endtask

   initial begin
      logic [4:0] v;
      ifm.clear = 1'b0; ifm.odd_mode = 1'b0; ifm.bit_valid = 1'b0; ifm.bit_in = 1'b0;
      #12;
      check("rst_busy", 32'(ifm.busy), 32'd0);
      check("rst_pec", 32'(ifm.pec), 32'd0);
      check("rst_cnt", 32'(ifm.err_cnt), 32'd0);
      check("rst_done", 32'(ifm.frame_done), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #2;
      run = 1'b1;

      // Exhaustive even-parity frames, back to back.
      for (int k = 0; k < 32; k++) begin
         v = 5'(k);
         send_frame(v[4:1], v[0], 1'b0);
         check("exh_done", 32'(ifm.frame_done), 32'd1);
         check("exh_pec", 32'(ifm.pec), 32'(^v));
      end
      check("exh_cnt8", 32'(ifm.err_cnt), 32'd16);
      check("exh_cnt2", 32'(ifs.err_cnt), 32'd3);
      do_clear(1'b0);
      check("clr_cnt", 32'(ifm.err_cnt), 32'd0);

      // Odd mode; odd_mode wiggles during data bits.
      send_frame(4'b1011, 1'b0, 1'b1);
      check("odd_p0", 32'(ifm.pec), 32'd0);
      send_frame(4'b1011, 1'b1, 1'b1);
      check("odd_p1", 32'(ifm.pec), 32'd1);
      for (int i = 3; i >= 0; i--) begin
         logic [3:0] d;
         d = 4'b1011;
         send(d[i], 1'($urandom_range(0, 1)));
      end
      send(1'b0, 1'b1);
      check("odd_tog", 32'(ifm.pec), 32'd0);

      // Gapped frame 0110 + parity 0.
      begin
         logic [4:0] g;
         g = 5'b01100;
         for (int i = 4; i >= 0; i--) begin
            send(g[i], 1'b0);
            if (i != 0) begin
               check("gap_busy", 32'(ifm.busy), 32'd1);
               idle(3);
               check("gap_nodone", 32'(ifm.frame_done), 32'd0);
            end
         end
         check("gap_done", 32'(ifm.frame_done), 32'd1);
         check("gap_pec", 32'(ifm.pec), 32'd0);
         check("gap_idle", 32'(ifm.busy), 32'd0);
         idle(1);
         check("gap_done1", 32'(ifm.frame_done), 32'd0);
      end

      // Abort mid-frame, with a bit dropped by clear.
      do_clear(1'b0);
      send(1'b0, 1'b0); send(1'b1, 1'b0);
      check("ab_busy", 32'(ifm.busy), 32'd1);
      do_clear(1'b1);
      check("ab_busy0", 32'(ifm.busy), 32'd0);
      check("ab_nodone", 32'(ifm.frame_done), 32'd0);
      send_frame(4'b1111, 1'b1, 1'b0);
      check("ab_pec", 32'(ifm.pec), 32'd1);
      check("ab_cnt", 32'(ifm.err_cnt), 32'd1);

      // Saturation on the narrow counter.
      do_clear(1'b0);
      for (int k = 1; k <= 5; k++) begin
         send_frame(4'b0000, 1'b1, 1'b0);
         check("sat_cnt2", 32'(ifs.err_cnt), 32'((k > 3) ? 3 : k));
         check("sat_cnt8", 32'(ifm.err_cnt), 32'(k));
      end

      // Async reset mid-frame, between edges.
      send(1'b1, 1'b0); send(1'b0, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      check("ar_busy", 32'(ifm.busy), 32'd0);
      check("ar_pec", 32'(ifs.pec), 32'd0);
      check("ar_cnt", 32'(ifs.err_cnt), 32'd0);
      check("ar_done", 32'(ifm.frame_done), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #2;
      send_frame(4'b0001, 1'b1, 1'b0);
      check("ar_fr_done", 32'(ifm.frame_done), 32'd1);
      check("ar_fr_pec", 32'(ifm.pec), 32'd0);

      // Random stream with occasional clears.
      for (int k = 0; k < 3000; k++) begin
         ifm.bit_valid = 1'($urandom_range(0, 3) != 0);
         ifm.bit_in    = 1'($urandom_range(0, 1));
         ifm.odd_mode  = 1'($urandom_range(0, 1));
         ifm.clear     = 1'($urandom_range(0, 79) == 0);
         @(posedge clk); #2;
      end
      ifm.bit_valid = 1'b0; ifm.clear = 1'b0;
      idle(2);
      run = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/serial_parity_checker.md
Name: serial_parity_checker

Overview:
- Parametrised, clocked successor to the combinational 4-bit parity checker.
- Accepts one frame as a serial bit stream: DATA_W data bits, then one parity bit.
- At frame end, produces a registered parity-error flag with a one-cycle done strobe, and keeps a saturating error count.
- Supports even or odd parity per frame, and a synchronous clear that aborts a frame in progress.
- Sits between a serial receiver front end and the status/LED logic.

Parameters:
- DATA_W, 4, number of data bits per frame (>=1); the parity bit follows them.
- CNT_W, 8, width of the saturating error counter (>=1).
- IDX_W, $clog2(DATA_W+1), width of the internal bit index (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous clear; aborts the current frame and zeroes the counters.
- odd_mode  input  1  0 = even parity, 1 = odd parity; sampled only on the parity-bit cycle.
- bit_valid  input  1  bit_in is valid this cycle.
- bit_in  input  1  serial data/parity bit.
- busy  output  1  a frame is partially received (bit index != 0).
- frame_done  output  1  one-cycle pulse, the cycle after a parity bit is accepted.
- pec  output  1  parity error of the last completed frame; held until the next frame_done or clear.
- err_cnt  output  CNT_W  number of frames with pec=1; saturates.

Behaviour:
- Reset (rst_n=0, async): bit index=0, accumulator=0, busy=0, frame_done=0, pec=0, err_cnt=0.
- Internal state: bit index idx (0..DATA_W) and XOR accumulator acc. There is no explicit FSM beyond idx: idx=0 is IDLE, idx 1..DATA_W-1 is DATA, idx=DATA_W is PARITY.
- Priority per clock edge: clear > bit_valid > hold.
- clear=1: idx=0, acc=0, pec=0, err_cnt=0, frame_done=0. Any partial frame is discarded; bit_valid in the same cycle is ignored.
- bit_valid=1, idx<DATA_W: acc <= acc ^ bit_in; idx <= idx+1; frame_done <= 0.
- bit_valid=1, idx==DATA_W (parity bit):
  - result = acc ^ bit_in ^ odd_mode.
  - pec <= result; frame_done <= 1; idx <= 0; acc <= 0.
  - If result=1 and err_cnt != all-ones, err_cnt <= err_cnt+1.
- bit_valid=0: idx, acc, pec and err_cnt hold; frame_done <= 0. Gaps between bits are allowed at any length.
- Even mode: pec=1 iff the total number of ones across data+parity is odd. This is identical to the 5-input XOR of the original block when DATA_W=4.
- Odd mode: pec=1 iff the total number of ones is even.
- Latency: pec and frame_done update on the edge that accepts the parity bit, so they are visible the following cycle. frame_done is never high two cycles in a row unless parity bits arrive back to back; that is impossible for DATA_W>=1.
- Back-to-back frames need no idle cycle: the bit after a parity bit is data bit 0 of the next frame.
- err_cnt saturates at 2^CNT_W-1 and never wraps; only clear or reset returns it to 0.
- busy = (idx != 0), registered-derived, with no combinational path from inputs.
- Reset or clear mid-frame: the partial frame produces no frame_done and does not affect pec or err_cnt.

Test Plan:
- Exhaustive even mode, DATA_W=4: stream all 32 data+parity combinations back to back.
  - Each frame gives frame_done one cycle after its parity bit.
  - pec equals the XOR of the 5 bits; err_cnt=16 at the end.
- Odd mode: data 1011, parity 0 -> pec=0.
  - Data 1011, parity 1 -> pec=1.
  - odd_mode toggled during data bits has no effect; only its value on the parity cycle matters.
- Gapped input: frame 0110 + parity 0 with 3 idle cycles between every bit.
  - busy=1 from the first bit until the parity edge; then pec=0, frame_done=1 for exactly one cycle.
- Abort: send 2 data bits, assert clear, then send full frame 1111 + parity 1.
  - No frame_done for the aborted frame; pec=1 after the second frame; err_cnt=1.
  - clear together with bit_valid drops that bit.
- Saturation with CNT_W=2: 5 consecutive error frames -> err_cnt sequence 1,2,3,3,3. Then clear -> err_cnt=0, pec=0.
- Async reset: assert rst_n=0 between clock edges mid-frame.
  - All outputs go to 0 immediately.
  - After release, a fresh frame 0001 + parity 1 (even) -> pec=0.
